// File: rtl/press_classifier.sv
// Button press classifier: turns a debounced button level into short, long
// and double press pulses, with a saturating count of classified events.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | button released, no press in progress
// HELD     | button down, cnt counts hold cycles toward a long press
// GAP      | released after a short hold, cnt counts the gap toward short
// WAIT_REL | press already classified, wait for release without emitting
module press_classifier #(
    parameter int LONG_CNT = 16,
    parameter int GAP_CNT  = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       db_in,
    output logic       short_press,
    output logic       long_press,
    output logic       double_press,
    output logic       busy,
    output logic [7:0] evt_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HELD     = 2'd1,
        GAP      = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             double_q, double_d;
    logic [7:0]       evt_q, evt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            evt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            evt_q    <= evt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (db_in) state_d = HELD;
            end
            HELD: begin
                if (!db_in) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = WAIT_REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            GAP: begin
                if (db_in) begin
                    state_d = WAIT_REL;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_REL: begin
                cnt_d = '0;
                if (!db_in) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pulses are decided from the current state so they register on the
    // same edge as the transition that classifies the press.
    always_comb begin
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        case (state_q)
            HELD:    long_d = db_in && (cnt_q == LONG_LAST);
            GAP: begin
                double_d = db_in;
                short_d  = !db_in && (cnt_q == GAP_LAST);
            end
            default: ;
        endcase
        evt_d = evt_q;
        if ((short_d || long_d || double_d) && (evt_q != 8'hFF))
            evt_d = evt_q + 8'd1;
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_press = double_q;
    assign evt_cnt      = evt_q;
    assign busy         = (state_q != IDLE);

endmodule
